muldiv_ctrl: RTL and testbench

//  Sequencer and owner of HI/LO for the iterative multiply/divide engine in EX.

---
 rtl/muldiv_ctrl_if.sv | 24 ++
 rtl/muldiv_ctrl.sv | 166 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// EX-side request/response bundle for the HI/LO multiply/divide sequencer.
// master = EX stage, slave = muldiv_ctrl.
interface muldiv_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req_valid;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_ready;
  logic             stall;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready, stall, rd_valid, rd_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready, stall, rd_valid, rd_data
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and launch/complete sequencer for the iterative mul/div engine, with watchdog.
// Optional feature: define MULDIV_DIVZERO_EN to resolve divide-by-zero locally without launching.
module muldiv_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  muldiv_ctrl_if.slave       ex,
  output logic               eng_start,
  output logic [1:0]         eng_op,
  output logic [WIDTH-1:0]   eng_a,
  output logic [WIDTH-1:0]   eng_b,
  input  logic               eng_busy,
  input  logic [2*WIDTH-1:0] eng_out,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               timeout_err,
  output logic               div_zero
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_e;
  typedef enum logic [2:0] {
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO
  } op_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] eng_a_q, eng_a_d, eng_b_q, eng_b_d;
  logic [1:0]       eng_op_q, eng_op_d;
  logic             eng_start_q, eng_start_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             timeout_q, timeout_d;
  logic             div_zero_q, div_zero_d;
  logic             accept;
  logic             dz_hit;
  op_e              op;

  assign op     = op_e'(ex.req_op);
  assign accept = ex.req_valid && (state_q == IDLE);

`ifdef MULDIV_DIVZERO_EN
  assign dz_hit = ex.req_op[1] && (ex.req_b == '0);
`else
  assign dz_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    eng_a_d    = eng_a_q;
    eng_b_d    = eng_b_q;
    eng_op_d   = eng_op_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    timeout_d  = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              if (dz_hit) begin
                hi_d       = ex.req_a;
                lo_d       = '1;
                div_zero_d = 1'b1;
              end else begin
                eng_a_d  = ex.req_a;
                eng_b_d  = ex.req_b;
                eng_op_d = {ex.req_op[1], ~ex.req_op[0]};
                cnt_d    = '0;
                state_d  = LAUNCH;
              end
            end
            OP_MFHI: begin
              rd_valid_d = 1'b1;
              rd_data_d  = hi_q;
            end
            OP_MFLO: begin
              rd_valid_d = 1'b1;
              rd_data_d  = lo_q;
            end
            OP_MTHI: hi_d = ex.req_a;
            OP_MTLO: lo_d = ex.req_a;
            default: ;
          endcase
        end
      end
      LAUNCH: begin
        cnt_d = cnt_q + CW'(1);
        // Completion is only possible from RUN, so the watchdog outranks busy here.
        if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else if (eng_busy) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (!eng_busy) begin
          {hi_d, lo_d} = eng_out;
          state_d      = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    eng_start_d = (state_d == LAUNCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      eng_a_q     <= '0;
      eng_b_q     <= '0;
      eng_op_q    <= '0;
      eng_start_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      timeout_q   <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      eng_a_q     <= eng_a_d;
      eng_b_q     <= eng_b_d;
      eng_op_q    <= eng_op_d;
      eng_start_q <= eng_start_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      timeout_q   <= timeout_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign ex.req_ready = (state_q == IDLE);
  assign ex.stall     = ex.req_valid && (state_q != IDLE);
  assign ex.rd_valid  = rd_valid_q;
  assign ex.rd_data   = rd_data_q;
  assign eng_start    = eng_start_q;
  assign eng_op       = eng_op_q;
  assign eng_a        = eng_a_q;
  assign eng_b        = eng_b_q;
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign timeout_err  = timeout_q;
  assign div_zero     = div_zero_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural iterative engine of programmable latency.
module tb_muldiv_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        eng_start;
  logic [1:0]  eng_op;
  logic [31:0] eng_a, eng_b, hi, lo;
  logic        eng_busy;
  logic [63:0] eng_out;
  logic        timeout_err, div_zero;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned eng_lat;
  bit          stuck, kill;
  int unsigned left;

  muldiv_ctrl_if #(.WIDTH(32)) bus ();

  muldiv_ctrl #(.WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .ex(bus),
    .eng_start(eng_start), .eng_op(eng_op), .eng_a(eng_a), .eng_b(eng_b),
    .eng_busy(eng_busy), .eng_out(eng_out),
    .hi(hi), .lo(lo), .timeout_err(timeout_err), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    int                 sa, sb;
    sa = a;
    sb = b;
    case (op)
      2'b01: begin sp = 64'(sa) * 64'(sb); return sp; end
      2'b00: begin up = {32'h0, a} * {32'h0, b}; return up; end
      2'b11: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Engine: latch on start while idle, hold busy for eng_lat cycles, publish result as busy falls.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_busy <= 1'b0;
      eng_out  <= '0;
      left     <= 0;
    end else if (kill) begin
      eng_busy <= 1'b0;
    end else if (!eng_busy) begin
      if (eng_start) begin
        eng_busy <= 1'b1;
        left     <= eng_lat - 1;
      end
    end else if (!stuck) begin
      if (left == 0) begin
        eng_busy <= 1'b0;
        eng_out  <= calc(eng_op, eng_a, eng_b);
      end else begin
        left <= left - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(output int unsigned n);
    n = 0;
    while (!bus.req_ready && n < 100) begin
      step();
      n++;
    end
  endtask

  int unsigned n, s;

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op = 3'd0;
    bus.req_a = '0;
    bus.req_b = '0;
    eng_lat = 4;
    stuck = 1'b0;
    kill = 1'b0;

    #12;
    check("rst_ready", bus.req_ready, 1);
    check("rst_stall", bus.stall, 0);
    check("rst_rdv", bus.rd_valid, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_start", eng_start, 0);
    check("rst_to", timeout_err, 0);
    check("rst_dz", div_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // MTHI then MFHI
    bus.req_valid = 1'b1;
    bus.req_op = 3'd6;
    bus.req_a = 32'h1234_5678;
    check("mthi_ready", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    check("mthi_hi", hi, 64'h1234_5678);
    check("mthi_lo", lo, 0);
    issue(3'd4, 32'h0, 32'h0);
    check("mfhi_rdv", bus.rd_valid, 1);
    check("mfhi_data", bus.rd_data, 64'h1234_5678);
    step();
    check("mfhi_rdv_drop", bus.rd_valid, 0);

    // MULT -3*5 with MFLO stalled behind it
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    bus.req_valid = 1'b1;
    bus.req_op = 3'd5;
    check("mult_op", eng_op, 2'b01);
    check("mult_a", eng_a, 64'hFFFF_FFFD);
    check("mult_b", eng_b, 5);
    n = 0;
    s = 0;
    while (!bus.req_ready && n < 40) begin
      check("mult_stall", bus.stall, 1);
      check("mult_lo_hold", lo, 0);
      if (eng_start) s++;
      step();
      n++;
    end
    check("mult_busy_cycles", n, 6);
    check("mult_start_cycles", s, 2);
    check("mult_hi", hi, 64'hFFFF_FFFF);
    check("mult_lo", lo, 64'hFFFF_FFF1);
    check("mult_stall_clear", bus.stall, 0);
    step();
    bus.req_valid = 1'b0;
    check("mflo_rdv", bus.rd_valid, 1);
    check("mflo_data", bus.rd_data, 64'hFFFF_FFF1);

    // DIV -7/2 and MULTU 0xFFFFFFFF*2
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_op", eng_op, 2'b11);
    wait_idle(n);
    check("div_cycles", n, 6);
    check("div_hi", hi, 64'hFFFF_FFFF);
    check("div_lo", lo, 64'hFFFF_FFFD);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    check("multu_op", eng_op, 2'b00);
    wait_idle(n);
    check("multu_hi", hi, 1);
    check("multu_lo", lo, 64'hFFFF_FFFE);

    // Completion on the watchdog's last edge wins
    eng_lat = 14;
    issue(3'd1, 32'd3, 32'd4);
    wait_idle(n);
    check("race_cycles", n, 16);
    check("race_no_to", timeout_err, 0);
    check("race_hi", hi, 0);
    check("race_lo", lo, 12);

    // One cycle slower: watchdog fires
    eng_lat = 15;
    issue(3'd1, 32'd5, 32'd6);
    wait_idle(n);
    check("late_cycles", n, 16);
    check("late_to", timeout_err, 1);
    check("late_lo", lo, 12);
    step();
    check("late_to_drop", timeout_err, 0);
    n = 0;
    while (eng_busy && n < 50) begin
      step();
      n++;
    end

    // Engine stuck busy
    eng_lat = 4;
    stuck = 1'b1;
    issue(3'd0, 32'd9, 32'd9);
    wait_idle(n);
    check("stuck_cycles", n, 16);
    check("stuck_to", timeout_err, 1);
    check("stuck_hi", hi, 0);
    check("stuck_lo", lo, 12);
    kill = 1'b1;
    step();
    kill = 1'b0;
    stuck = 1'b0;
    check("stuck_to_drop", timeout_err, 0);
    bus.req_valid = 1'b1;
    bus.req_op = 3'd7;
    bus.req_a = 32'hCAFE_F00D;
    check("mtlo_ready", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    check("mtlo_lo", lo, 64'hCAFE_F00D);

    // DIVU 7/0
    issue(3'd3, 32'd7, 32'd0);
`ifdef MULDIV_DIVZERO_EN
    check("dz_ready", bus.req_ready, 1);
    check("dz_pulse", div_zero, 1);
    check("dz_no_start", eng_start, 0);
    check("dz_hi", hi, 7);
    check("dz_lo", lo, 64'hFFFF_FFFF);
    step();
    check("dz_drop", div_zero, 0);
    check("dz_no_start2", eng_start, 0);
`else
    check("dz_start", eng_start, 1);
    check("dz_flag0", div_zero, 0);
    wait_idle(n);
    check("dz_cycles", n, 6);
    check("dz_flag1", div_zero, 0);
    check("dz_hi", hi, 7);
    check("dz_lo", lo, 64'hFFFF_FFFF);
`endif

    // Asynchronous reset in the middle of RUN
    eng_lat = 10;
    issue(3'd0, 32'd2, 32'd3);
    step();
    step();
    step();
    check("mid_busy", bus.req_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", bus.req_ready, 1);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_start", eng_start, 0);
    check("arst_a", eng_a, 0);
    check("arst_op", eng_op, 0);
    check("arst_rd_data", bus.rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", bus.req_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
